// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed common-anode segment/enable bus
// and rebuilds the BCD digit, decimal point and frame/timeout status for each digit.
module sevenseg_scan_decoder #(
    parameter int DATAWIDTH      = 8,
    parameter int NUM_DISP       = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATAWIDTH-1:0]    sevensegment,
    input  logic [NUM_DISP-1:0]     enable,
    output logic [4*NUM_DISP-1:0]   digit_bcd,
    output logic [NUM_DISP-1:0]     digit_dp,
    output logic [NUM_DISP-1:0]     digit_valid,
    output logic                    frame_strobe,
    output logic                    code_err,
    output logic                    timeout
);

    localparam int SCW = $clog2(STABLE_CYCLES);
    localparam int TCW = $clog2(TIMEOUT_CYCLES);
    localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES - 1);
    localparam logic [TCW-1:0] TO_MAX     = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_DISP-1:0] SEL_ONE = NUM_DISP'(1);

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Active-low abcdefg pattern to BCD; 4'hF marks an unrecognised pattern.
    function automatic logic [3:0] decode7(input logic [6:0] abcdefg);
        logic [3:0] v;
        case (abcdefg)
            7'b0000001: v = 4'd0;
            7'b1001111: v = 4'd1;
            7'b0010010: v = 4'd2;
            7'b0000110: v = 4'd3;
            7'b1001100: v = 4'd4;
            7'b0100100: v = 4'd5;
            7'b0100000: v = 4'd6;
            7'b0001111: v = 4'd7;
            7'b0000000: v = 4'd8;
            7'b0001100: v = 4'd9;
            default:    v = 4'hF;
        endcase
        return v;
    endfunction

    function automatic logic [SCW-1:0] stable_next(input logic [SCW-1:0] cnt,
                                                   input logic          changed);
        logic [SCW-1:0] v;
        if (changed)
            v = '0;
        else if (cnt == STABLE_MAX)
            v = cnt;
        else
            v = cnt + SCW'(1);
        return v;
    endfunction

    function automatic logic [TCW-1:0] timeout_next(input logic [TCW-1:0] cnt);
        return (cnt == TO_MAX) ? cnt : cnt + TCW'(1);
    endfunction

    logic [DATAWIDTH-1:0]  r_seg_p0, r_seg_p1, r_seg_p2;
    logic [NUM_DISP-1:0]   r_en_p0, r_en_p1, r_en_p2;
    logic [SCW-1:0]        r_stable_cnt;
    state_t                r_state, w_state_next;
    logic                  w_capture;
    logic                  w_changed;
    logic [NUM_DISP-1:0]   w_sel;
    logic                  w_eligible;
    logic [3:0]            w_dec;
    logic [TCW-1:0]        w_to_next;

    logic [4*NUM_DISP-1:0] r_bcd;
    logic [NUM_DISP-1:0]   r_dp;
    logic [NUM_DISP-1:0]   r_valid;
    logic [NUM_DISP-1:0]   r_mask;
    logic                  r_frame;
    logic                  r_err;
    logic [TCW-1:0]        r_to_cnt;
    logic                  r_timeout;

    // p0/p1: two-flop synchronizer, p1 is the working sample; p2 is the previous sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_p0 <= '1;
            r_seg_p1 <= '1;
            r_seg_p2 <= '1;
            r_en_p0  <= '1;
            r_en_p1  <= '1;
            r_en_p2  <= '1;
        end else begin
            r_seg_p0 <= sevensegment;
            r_seg_p1 <= r_seg_p0;
            r_seg_p2 <= r_seg_p1;
            r_en_p0  <= enable;
            r_en_p1  <= r_en_p0;
            r_en_p2  <= r_en_p1;
        end
    end

    assign w_changed  = (r_seg_p1 != r_seg_p2) || (r_en_p1 != r_en_p2);
    assign w_sel      = ~r_en_p1;
    assign w_eligible = (w_sel != '0) && ((w_sel & (w_sel - SEL_ONE)) == '0);
    assign w_dec      = decode7(r_seg_p1[7:1]);
    assign w_to_next  = timeout_next(r_to_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable_cnt <= '0;
            r_state      <= SETTLE;
        end else begin
            r_stable_cnt <= stable_next(r_stable_cnt, w_changed);
            r_state      <= w_state_next;
        end
    end

    // Capture fires on the SETTLE->CAPTURE transition so outputs land on that same edge.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            SETTLE: begin
                if (!w_changed && (r_stable_cnt == STABLE_MAX) && w_eligible) begin
                    w_state_next = CAPTURE;
                    w_capture    = 1'b1;
                end
            end
            CAPTURE: begin
                w_state_next = w_changed ? SETTLE : HOLD;
            end
            HOLD: begin
                if (w_changed)
                    w_state_next = SETTLE;
            end
            default: begin
                w_state_next = SETTLE;
            end
        endcase
    end

    // capture / frame / timeout stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd     <= '1;
            r_dp      <= '0;
            r_valid   <= '0;
            r_mask    <= '0;
            r_frame   <= 1'b0;
            r_err     <= 1'b0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            r_err   <= 1'b0;
            if (w_capture) begin
                for (int i = 0; i < NUM_DISP; i++) begin
                    if (w_sel[i]) begin
                        r_bcd[4*i +: 4] <= w_dec;
                        r_dp[i]         <= ~r_seg_p1[0];
                    end
                end
                r_valid <= r_valid | w_sel;
                if ((r_mask | w_sel) == '1) begin
                    r_mask  <= '0;
                    r_frame <= 1'b1;
                end else begin
                    r_mask <= r_mask | w_sel;
                end
                r_err     <= (w_dec == 4'hF);
                r_to_cnt  <= '0;
                r_timeout <= 1'b0;
            end else begin
                r_to_cnt <= w_to_next;
                // Displayed digits are kept on timeout; only validity and frame progress drop.
                if (w_to_next == TO_MAX) begin
                    r_timeout <= 1'b1;
                    r_valid   <= '0;
                    r_mask    <= '0;
                end
            end
        end
    end

    assign digit_bcd    = r_bcd;
    assign digit_dp     = r_dp;
    assign digit_valid  = r_valid;
    assign frame_strobe = r_frame;
    assign code_err     = r_err;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: expected captures are queued when a dwell
// is driven and compared on the cycle the decoder should publish them.
module tb_sevenseg_scan_decoder;

    localparam int STABLE = 16;
    localparam int TMO    = 100;
    localparam int LAT    = STABLE + 3;

    localparam logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                         7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                         7'b0000000, 7'b0001100};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  en;
    logic [15:0] digit_bcd;
    logic [3:0]  digit_dp;
    logic [3:0]  digit_valid;
    logic        frame_strobe;
    logic        code_err;
    logic        timeout;

    sevenseg_scan_decoder #(
        .DATAWIDTH(8), .NUM_DISP(4), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .sevensegment(seg), .enable(en),
        .digit_bcd(digit_bcd), .digit_dp(digit_dp), .digit_valid(digit_valid),
        .frame_strobe(frame_strobe), .code_err(code_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         idx;
        logic [3:0] bcd;
        logic [3:0] old;
        logic       dp;
        logic       err;
        logic       frame;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [3:0] mdl_bcd [4];
    logic [3:0] mdl_mask;
    logic [7:0] last_seg;
    logic [3:0] last_en;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_frames = 0;
    int         n_codeerr = 0;
    int         d;
    int         p_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 10; k++)
            if (PAT[k] == p) return 4'(k);
        return 4'hF;
    endfunction

    // Drive one dwell; a long-enough eligible dwell queues its expected capture.
    task automatic step(input logic [7:0] s, input logic [3:0] e, input int n, output int due);
        exp_t it;
        int   idx;
        due = -1;
        seg = s;
        en  = e;
        if ((s != last_seg || e != last_en) && n >= LAT + 1 && $countones(~e) == 1) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (!e[k]) idx = k;
            it.due   = cyc + LAT;
            it.idx   = idx;
            it.old   = mdl_bcd[idx];
            it.bcd   = ref_decode(s[7:1]);
            it.dp    = ~s[0];
            it.err   = (it.bcd == 4'hF);
            mdl_bcd[idx]  = it.bcd;
            mdl_mask[idx] = 1'b1;
            it.frame = (mdl_mask == 4'hF);
            if (it.frame) mdl_mask = 4'h0;
            sb.push_back(it);
            due = it.due;
        end
        last_seg = s;
        last_en  = e;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (frame_strobe === 1'b1) n_frames++;
        if (code_err === 1'b1) n_codeerr++;
        if (sb.size() > 0) begin
            if (sb[0].due - 1 == cyc)
                chk("pre_capture_digit", 32'(digit_bcd[4*sb[0].idx +: 4]), 32'(sb[0].old));
            if (sb[0].due == cyc) begin
                cur = sb.pop_front();
                chk("cap_bcd",   32'(digit_bcd[4*cur.idx +: 4]), 32'(cur.bcd));
                chk("cap_dp",    32'(digit_dp[cur.idx]), 32'(cur.dp));
                chk("cap_valid", 32'(digit_valid[cur.idx]), 32'd1);
                chk("cap_err",   32'(code_err), 32'(cur.err));
                chk("cap_frame", 32'(frame_strobe), 32'(cur.frame));
            end
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) mdl_bcd[k] = 4'hF;
        mdl_mask = 4'h0;
        rst = 1'b1;
        seg = 8'h5A;
        en  = 4'b0110;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(digit_bcd), 32'hFFFF);
        chk("rst_dp", 32'(digit_dp), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_frame", 32'(frame_strobe), 32'h0);
        chk("rst_err", 32'(code_err), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0;
        seg = 8'hFF;
        en  = 4'hF;
        last_seg = seg;
        last_en  = en;
        @(negedge clk);

        // full scan of 1,2,3,4 with dp lit and blanking gaps
        step(8'b10011110, 4'b1110, 40, d); step(8'hFF, 4'hF, 4, d);
        step(8'b00100100, 4'b1101, 40, d); step(8'hFF, 4'hF, 4, d);
        step(8'b00001100, 4'b1011, 40, d); step(8'hFF, 4'hF, 4, d);
        step(8'b10011000, 4'b0111, 40, d); step(8'hFF, 4'hF, 4, d);
        chk("scan_bcd", 32'(digit_bcd), 32'h4321);
        chk("scan_dp", 32'(digit_dp), 32'hF);
        chk("scan_valid", 32'(digit_valid), 32'hF);
        chk("scan_frames", 32'(n_frames), 32'd1);
        chk("scan_timeout", 32'(timeout), 32'h0);

        // glitch: "5" on digit 0 with the bus toggling against "8"
        step(8'b01001001, 4'b1110, 4, d);
        for (int k = 0; k < 5; k++)
            step((k % 2 == 0) ? 8'b00000001 : 8'b01001001, 4'b1110, 1, d);
        step(8'b01001001, 4'b1110, 40, d);
        chk("glitch_digit0", 32'(digit_bcd[3:0]), 32'h5);
        chk("glitch_no_err", 32'(n_codeerr), 32'd0);
        step(8'hFF, 4'hF, 4, d);

        // unrecognised pattern on digit 0
        step(8'b11111110, 4'b1110, 30, d);
        chk("bad_bcd", 32'(digit_bcd), 32'h432F);
        chk("bad_err_count", 32'(n_codeerr), 32'd1);
        chk("bad_valid0", 32'(digit_valid[0]), 32'h1);
        step(8'hFF, 4'hF, 4, d);

        // two enables low: must be ignored
        step(8'b00000001, 4'b1100, 60, d);
        chk("multi_bcd", 32'(digit_bcd), 32'h432F);
        chk("multi_dp", 32'(digit_dp), 32'hF);
        chk("multi_valid", 32'(digit_valid), 32'hF);
        chk("multi_err_count", 32'(n_codeerr), 32'd1);
        chk("multi_timeout", 32'(timeout), 32'h0);

        // capture all digits, then starve the bus until timeout
        step(8'b01001001, 4'b1110, 24, d);
        step(8'b01000001, 4'b1101, 24, d);
        step(8'b00011111, 4'b1011, 24, d);
        step(8'b00011001, 4'b0111, 24, p_last);
        seg = 8'hFF;
        en  = 4'hF;
        last_seg = seg;
        last_en  = en;
        wait_cyc(p_last + TMO - 2);
        chk("pre_timeout_level", 32'(timeout), 32'h0);
        chk("pre_timeout_valid", 32'(digit_valid), 32'hF);
        @(negedge clk);
        chk("timeout_level", 32'(timeout), 32'h1);
        chk("timeout_valid", 32'(digit_valid), 32'h0);
        chk("timeout_bcd_kept", 32'(digit_bcd), 32'h9765);
        mdl_mask = 4'h0;
        @(negedge clk);
        chk("timeout_held", 32'(timeout), 32'h1);
        step(8'b00000001, 4'b1011, 30, d);
        chk("recover_timeout", 32'(timeout), 32'h0);
        chk("recover_valid", 32'(digit_valid), 32'h4);
        chk("recover_bcd", 32'(digit_bcd), 32'h9865);
        step(8'hFF, 4'hF, 4, d);

        // reset lands on the edge the capture would have happened
        seg = 8'b00001101;
        en  = 4'b1101;
        last_seg = seg;
        last_en  = en;
        wait_cyc(cyc + LAT - 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_bcd", 32'(digit_bcd), 32'hFFFF);
        chk("midrst_valid", 32'(digit_valid), 32'h0);
        chk("midrst_dp", 32'(digit_dp), 32'h0);
        chk("midrst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0;
        seg = 8'hFF;
        en  = 4'hF;
        repeat (5) @(negedge clk);
        chk("postrst_bcd", 32'(digit_bcd), 32'hFFFF);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("total_frames", 32'(n_frames), 32'd2);
        chk("total_code_err", 32'(n_codeerr), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
